// File: rtl/load_store_unit.sv
// Load/store initiator for a 256x32 synchronous data memory. Latency: error 1, word store 2,
// load 3, subword store 4 cycles; req_ready high only in IDLE, so one transaction at a time.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [31:0] byte_sel, half_sel, load_val;
    logic [31:0] byte_mask, half_mask, merged;

    assign req_err = (req_size == 2'd3)
                  || (req_size == 2'd1 && req_addr[0])
                  || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                  || (req_addr >= ADDR_LIMIT);

    // Little-endian lanes: shift the target lane down to bit 0 for loads, up for merges.
    assign byte_sel  = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sel  = mem_rdata >> {addr_q[1], 4'b0000};
    assign byte_mask = 32'h0000_00ff << {addr_q[1:0], 3'b000};
    assign half_mask = 32'h0000_ffff << {addr_q[1], 4'b0000};

    always_comb begin
        load_val = mem_rdata;
        merged   = mem_rdata;
        case (size_q)
            2'd0: begin
                load_val = {{24{~unsigned_q & byte_sel[7]}}, byte_sel[7:0]};
                merged   = (mem_rdata & ~byte_mask)
                         | (({24'b0, word_q[7:0]} << {addr_q[1:0], 3'b000}) & byte_mask);
            end
            2'd1: begin
                load_val = {{16{~unsigned_q & half_sel[15]}}, half_sel[15:0]};
                merged   = (mem_rdata & ~half_mask)
                         | (({16'b0, word_q[15:0]} << {addr_q[1], 4'b0000}) & half_mask);
            end
            default: begin
                load_val = mem_rdata;
                merged   = mem_rdata;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    word_d     = req_wdata;
                    rdata_d    = 32'd0;
                    err_d      = req_err;
                    if (req_err)
                        state_d = RESP;
                    else if (req_write && req_size == 2'd2)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (write_q) begin
                    word_d  = merged;
                    state_d = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            word_q     <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // A write in flight when reset hits must not reach the memory.
    assign mem_write  = (state_q == WR) && !rst;
    assign mem_read   = (state_q == RD);
    assign mem_addr   = (state_q == RD || state_q == WR) ? {2'b00, addr_q[31:2]} : 32'd0;
    assign mem_wdata  = (state_q == WR) ? word_q : 32'd0;
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;

endmodule
